tg68k_sram_ctrl: RTL and testbench
==================================

Name: tg68k_sram_ctrl

Overview:
Bus responder between the TG68K kernel bus (addr, data_write, nWr, nUDS/nLDS, busstate) and an asynchronous 16-bit SRAM (IS61LV6416L class).
It decodes each CPU bus cycle and sequences ce/oe/we/ub/lb with programmable wait states.
It returns read data and drives the CPU clkena, so the CPU advances exactly once per completed cycle.
It replaces free-running clkena dividers in the Minimig CPU/memory path.

Parameters:
ADR_BITS, 18, SRAM word-address width; uses cpu_adr[ADR_BITS:1].
RD_WAIT, 2, cycles oe_n held low before read data is sampled (1..15).
WR_WAIT, 2, cycles we_n held low per write (1..15).

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
cpu_adr  in  32  CPU byte address.
cpu_busstate  in  2  00 fetch, 10 read, 11 write, 01 no memory access.
cpu_we_n  in  1  CPU nWr; 0 = write.
cpu_uds_n  in  1  upper-byte strobe, active low.
cpu_lds_n  in  1  lower-byte strobe, active low.
cpu_dat_w  in  16  CPU write data.
cpu_dat_r  out  16  read data returned to CPU.
cpu_clkena  out  1  one-cycle CPU advance pulse.
sram_addr  out  ADR_BITS  SRAM word address.
sram_dat_w  out  16  SRAM write data.
sram_dat_r  in  16  SRAM read data (from the top-level tristate).
sram_dq_oe  out  1  1 = top level drives sram_dat_w onto dq.
sram_ce_n  out  1  chip enable.
sram_oe_n  out  1  output enable.
sram_we_n  out  1  write enable.
sram_ub_n  out  1  upper byte lane.
sram_lb_n  out  1  lower byte lane.

Behaviour:
- Reset values (next edge with rst=1, from any state, including mid-cycle):
  - state IDLE
  - cpu_clkena=0, cpu_dat_r=0
  - sram_ce_n=oe_n=we_n=ub_n=lb_n=1
  - sram_dq_oe=0, sram_addr=0, sram_dat_w=0
- FSM states: IDLE, SETUP, ACCESS, DONE (plus HOLD under the optional feature).
- IDLE: all SRAM controls inactive; clkena=0. Sample the CPU bus.
  - busstate==01: go to DONE.
  - Otherwise: latch adr[ADR_BITS:1], dat_w, uds_n/lds_n and write = (busstate==11 && !cpu_we_n); go to SETUP.
  - busstate==11 with cpu_we_n=1 is treated as a read.
- SETUP (1 cycle): ce_n=0, address valid.
  - Read: oe_n=0, ub_n=lb_n=0 (full word read).
  - Write: dq_oe=1, we_n=1, lanes from the latched strobes.
  - Load wait counter with RD_WAIT-1 or WR_WAIT-1; go to ACCESS.
- ACCESS: hold SETUP outputs. For a write, we_n=0 unless both latched strobes are 1 (null write: we_n stays 1).
  - Decrement the counter each cycle.
  - At counter 0: a read registers sram_dat_r into cpu_dat_r; go to DONE.
- DONE (1 cycle): ce_n=oe_n=we_n=1, dq_oe=0, cpu_clkena=1. Go to IDLE.
- Latency, IDLE-sample to clkena: read/fetch 3+RD_WAIT cycles; write 3+WR_WAIT; no-access 2.
- Address/data/lanes are stable from SETUP through DONE. we_n never overlaps an address change.
- cpu_dat_r holds its value until the next read completes; writes and no-access cycles leave it unchanged.
- Addresses beyond 2^ADR_BITS words wrap: upper bits are ignored.
- cpu_clkena is never high two consecutive cycles.
- Counter is 4 bits. Parameter values outside 1..15 are a configuration error, caught by an elaboration-time check.

Optional Feature:
Macro TG68K_SRAM_CTRL_WR_HOLD_EN.
- Defined: after a write ACCESS, insert HOLD (1 cycle) before DONE. In HOLD: we_n=1, ce_n=0, dq_oe=1, address and data held, giving data/address hold after the we_n rising edge. Write latency becomes 4+WR_WAIT.
- Undefined: no HOLD state; writes go ACCESS to DONE.
- Reads are unaffected either way.

Decomposition:
- Package tg68k_sram_pkg:
  - busstate encodings BS_FETCH=2'b00, BS_IDLE=2'b01, BS_READ=2'b10, BS_WRITE=2'b11
  - FSM state encoding
  - wait-counter width constant (4)
- One natural sub-module, tg68k_sram_wait_cnt: loadable down-counter with a zero flag.
- Everything else stays in one module.

Test Plan:
- Read: SRAM word 3 = 16'h0008, busstate=10, adr=32'h6 → sram_addr=3; oe_n low 1+RD_WAIT cycles; cpu_dat_r=16'h0008; clkena exactly 5 cycles after the IDLE sample (defaults).
- Upper-byte write: adr=32'h50, dat_w=16'hABCD, uds_n=0, lds_n=1 → ub_n=0, lb_n=1, we_n low exactly 2 cycles; word 0x28 upper byte=8'hAB, lower byte unchanged; cpu_dat_r unchanged.
- busstate=01 held → clkena pulses every 2nd cycle; ce_n stays 1 throughout.
- Null write (both strobes 1) → we_n never low; clkena still issued after 5 cycles.
- rst=1 during write ACCESS → next edge we_n=1, ce_n=1, dq_oe=0, clkena=0, cpu_dat_r=0; SRAM content unchanged beyond the cycles we_n was low.
- Wrap: adr=32'h0008_0006, ADR_BITS=18 → sram_addr=18'h00003. With TG68K_SRAM_CTRL_WR_HOLD_EN defined, a write shows a 1-cycle we_n=1/ce_n=0/dq_oe=1 gap before DONE.

Source files
------------

// File: rtl/tg68k_sram_pkg.sv
// Shared encodings for the TG68K-to-async-SRAM bus responder.
// TG68K_SRAM_CTRL_WR_HOLD_EN enables the HOLD state after write strobes.
package tg68k_sram_pkg;

  localparam logic [1:0] BS_FETCH = 2'b00;
  localparam logic [1:0] BS_IDLE  = 2'b01;
  localparam logic [1:0] BS_READ  = 2'b10;
  localparam logic [1:0] BS_WRITE = 2'b11;

  localparam int WCNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tg68k_sram_wait_cnt.sv
// Loadable wait-state down-counter; saturates at zero and flags it.
module tg68k_sram_wait_cnt
  import tg68k_sram_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WCNT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WCNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tg68k_sram_ctrl.sv
// TG68K bus responder for a 16-bit async SRAM with programmable wait states.
// Optional macro TG68K_SRAM_CTRL_WR_HOLD_EN adds a 1-cycle write hold state.
module tg68k_sram_ctrl
  import tg68k_sram_pkg::*;
#(
  parameter int ADR_BITS = 18,
  parameter int RD_WAIT  = 2,
  parameter int WR_WAIT  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [31:0]         i_cpu_adr,
  input  logic [1:0]          i_cpu_busstate,
  input  logic                i_cpu_we_n,
  input  logic                i_cpu_uds_n,
  input  logic                i_cpu_lds_n,
  input  logic [15:0]         i_cpu_dat_w,
  output logic [15:0]         o_cpu_dat_r,
  output logic                o_cpu_clkena,
  output logic [ADR_BITS-1:0] o_sram_addr,
  output logic [15:0]         o_sram_dat_w,
  input  logic [15:0]         i_sram_dat_r,
  output logic                o_sram_dq_oe,
  output logic                o_sram_ce_n,
  output logic                o_sram_oe_n,
  output logic                o_sram_we_n,
  output logic                o_sram_ub_n,
  output logic                o_sram_lb_n
);

  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("RD_WAIT must be in 1..15");
  end
  if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("WR_WAIT must be in 1..15");
  end

  localparam logic [WCNT_W-1:0] RD_LOAD = WCNT_W'(RD_WAIT - 1);
  localparam logic [WCNT_W-1:0] WR_LOAD = WCNT_W'(WR_WAIT - 1);

  state_t r_state, w_state_next;

  logic [ADR_BITS-1:0] r_addr;
  logic [15:0]         r_dat_w;
  logic [15:0]         r_dat_r;
  logic                r_write;
  logic                r_uds_n;
  logic                r_lds_n;
  // Lane enables as driven to the SRAM: forced on for reads, strobes for writes.
  logic                r_ub_n;
  logic                r_lb_n;

  logic w_latch, w_capture, w_load, w_dec, w_zero, w_null_wr;
  logic w_unused;

  assign w_unused  = ^{i_cpu_adr[31:ADR_BITS+1], i_cpu_adr[0]};
  assign w_null_wr = r_uds_n & r_lds_n;

  tg68k_sram_wait_cnt u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (r_write ? WR_LOAD : RD_LOAD),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dat_w <= '0;
      r_dat_r <= '0;
      r_write <= 1'b0;
      r_uds_n <= 1'b1;
      r_lds_n <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr  <= i_cpu_adr[ADR_BITS:1];
        r_dat_w <= i_cpu_dat_w;
        r_write <= (i_cpu_busstate == BS_WRITE) && !i_cpu_we_n;
        r_uds_n <= i_cpu_uds_n;
        r_lds_n <= i_cpu_lds_n;
        r_ub_n  <= ((i_cpu_busstate == BS_WRITE) && !i_cpu_we_n) ? i_cpu_uds_n : 1'b0;
        r_lb_n  <= ((i_cpu_busstate == BS_WRITE) && !i_cpu_we_n) ? i_cpu_lds_n : 1'b0;
      end
      if (w_capture) begin
        r_dat_r <= i_sram_dat_r;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    o_cpu_clkena = 1'b0;
    o_sram_ce_n  = 1'b1;
    o_sram_oe_n  = 1'b1;
    o_sram_we_n  = 1'b1;
    o_sram_dq_oe = 1'b0;
    o_sram_ub_n  = 1'b1;
    o_sram_lb_n  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (i_cpu_busstate == BS_IDLE) begin
          w_state_next = ST_DONE;
        end else begin
          w_latch      = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        o_sram_ce_n  = 1'b0;
        o_sram_oe_n  = r_write;
        o_sram_dq_oe = r_write;
        o_sram_ub_n  = r_ub_n;
        o_sram_lb_n  = r_lb_n;
        w_load       = 1'b1;
        w_state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_sram_ce_n  = 1'b0;
        o_sram_oe_n  = r_write;
        o_sram_dq_oe = r_write;
        o_sram_we_n  = !(r_write && !w_null_wr);
        o_sram_ub_n  = r_ub_n;
        o_sram_lb_n  = r_lb_n;
        w_dec        = 1'b1;
        if (w_zero) begin
          w_capture = !r_write;
`ifdef TG68K_SRAM_CTRL_WR_HOLD_EN
          w_state_next = r_write ? ST_HOLD : ST_DONE;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef TG68K_SRAM_CTRL_WR_HOLD_EN
      ST_HOLD: begin
        // we_n has risen; keep chip, bus and lanes driven for data hold time.
        o_sram_ce_n  = 1'b0;
        o_sram_dq_oe = 1'b1;
        o_sram_ub_n  = r_ub_n;
        o_sram_lb_n  = r_lb_n;
        w_state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_cpu_clkena = 1'b1;
        o_sram_ub_n  = r_ub_n;
        o_sram_lb_n  = r_lb_n;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_cpu_dat_r  = r_dat_r;
  assign o_sram_addr  = r_addr;
  assign o_sram_dat_w = r_dat_w;

endmodule

// File: tb/tb_tg68k_sram_ctrl.sv
// Directed, table-driven bench for tg68k_sram_ctrl with a behavioural async SRAM.
module tb_tg68k_sram_ctrl;

  localparam int ADR_BITS = 18;
`ifdef TG68K_SRAM_CTRL_WR_HOLD_EN
  localparam int WR_LAT = 6;
`else
  localparam int WR_LAT = 5;
`endif
  localparam int RD_LAT = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [31:0]         cpu_adr = '0;
  logic [1:0]          cpu_busstate = 2'b01;
  logic                cpu_we_n = 1'b1;
  logic                cpu_uds_n = 1'b1;
  logic                cpu_lds_n = 1'b1;
  logic [15:0]         cpu_dat_w = '0;
  logic [15:0]         cpu_dat_r;
  logic                cpu_clkena;
  logic [ADR_BITS-1:0] sram_addr;
  logic [15:0]         sram_dat_w;
  logic [15:0]         sram_dat_r;
  logic                sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:(1<<ADR_BITS)-1];

  always #5 clk = ~clk;

  tg68k_sram_ctrl #(.ADR_BITS(ADR_BITS), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_adr(cpu_adr), .i_cpu_busstate(cpu_busstate),
    .i_cpu_we_n(cpu_we_n), .i_cpu_uds_n(cpu_uds_n), .i_cpu_lds_n(cpu_lds_n),
    .i_cpu_dat_w(cpu_dat_w), .o_cpu_dat_r(cpu_dat_r), .o_cpu_clkena(cpu_clkena),
    .o_sram_addr(sram_addr), .o_sram_dat_w(sram_dat_w), .i_sram_dat_r(sram_dat_r),
    .o_sram_dq_oe(sram_dq_oe), .o_sram_ce_n(sram_ce_n), .o_sram_oe_n(sram_oe_n),
    .o_sram_we_n(sram_we_n), .o_sram_ub_n(sram_ub_n), .o_sram_lb_n(sram_lb_n)
  );

  assign sram_dat_r = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] = sram_dat_w[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dat_w[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic prev_clkena = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (prev_clkena && cpu_clkena) begin
        errors++;
        $display("FAIL clkena_consecutive: got 1 expected 0");
      end
    end
    prev_clkena <= cpu_clkena;
  end

  typedef struct {
    logic [1:0]  bs;
    logic        wen, uds, lds;
    logic [31:0] adr;
    logic [15:0] dw;
    logic        pre_en;
    logic [17:0] pre_addr;
    logic [15:0] pre_val;
    int          exp_lat;
    logic [15:0] exp_dat_r;
    logic [17:0] exp_addr;
    int          exp_oe, exp_we;
    logic        exp_ub, exp_lb;
    logic [15:0] exp_mem;
  } vec_t;

  vec_t vecs [10];

  // Drive one CPU cycle from an IDLE cycle; returns at the following IDLE cycle.
  task automatic run_txn(input vec_t v, output int lat, output int oe_cnt, output int we_cnt,
                         output int ce_cnt, output logic [17:0] addr_seen,
                         output logic ub_seen, output logic lb_seen, output logic [15:0] dat_r);
    bit done = 0;
    cpu_busstate = v.bs; cpu_we_n = v.wen; cpu_uds_n = v.uds; cpu_lds_n = v.lds;
    cpu_adr = v.adr; cpu_dat_w = v.dw;
    lat = 1; oe_cnt = 0; we_cnt = 0; ce_cnt = 0;
    addr_seen = '1; ub_seen = 1'b1; lb_seen = 1'b1; dat_r = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      lat++;
      if (!sram_ce_n) begin
        ce_cnt++; addr_seen = sram_addr; ub_seen = sram_ub_n; lb_seen = sram_lb_n;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (cpu_clkena) begin
        done = 1; dat_r = cpu_dat_r;
      end
    end
    if (!done) begin
      lat = -1;
      chk("txn_timeout", 32'd1, 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat, oe_cnt, we_cnt, ce_cnt;
    logic [17:0] addr_seen;
    logic ub_seen, lb_seen;
    logic [15:0] dat_r;
    int wl;

    //          bs     wen   uds   lds   adr             dw       pre  paddr      pval      lat     dat_r     addr      oe we ub    lb    mem
    vecs[0] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0000_0006, 16'h0000, 1'b1, 18'h00003, 16'h0008, RD_LAT, 16'h0008, 18'h00003, 3, 0, 1'b0, 1'b0, 16'h0008};
    vecs[1] = '{2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 16'h0000, 1'b1, 18'h00080, 16'h1234, RD_LAT, 16'h1234, 18'h00080, 3, 0, 1'b0, 1'b0, 16'h1234};
    vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 32'h0000_0050, 16'hABCD, 1'b1, 18'h00028, 16'h5566, WR_LAT, 16'h1234, 18'h00028, 0, 2, 1'b0, 1'b1, 16'hAB66};
    vecs[3] = '{2'b11, 1'b0, 1'b1, 1'b0, 32'h0000_0052, 16'h1357, 1'b1, 18'h00029, 16'hFFFF, WR_LAT, 16'h1234, 18'h00029, 0, 2, 1'b1, 1'b0, 16'hFF57};
    vecs[4] = '{2'b11, 1'b0, 1'b0, 1'b0, 32'h0000_0060, 16'hCAFE, 1'b1, 18'h00030, 16'h0000, WR_LAT, 16'h1234, 18'h00030, 0, 2, 1'b0, 1'b0, 16'hCAFE};
    vecs[5] = '{2'b11, 1'b0, 1'b1, 1'b1, 32'h0000_0062, 16'h1111, 1'b1, 18'h00031, 16'h2222, WR_LAT, 16'h1234, 18'h00031, 0, 0, 1'b1, 1'b1, 16'h2222};
    vecs[6] = '{2'b11, 1'b1, 1'b0, 1'b0, 32'h0000_0060, 16'h9999, 1'b0, 18'h00030, 16'h0000, RD_LAT, 16'hCAFE, 18'h00030, 3, 0, 1'b0, 1'b0, 16'hCAFE};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 16'h4444, 1'b1, 18'h00100, 16'h7777, 2,      16'hCAFE, 18'h00000, 0, 0, 1'b1, 1'b1, 16'h7777};
    vecs[8] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0008_0006, 16'h0000, 1'b0, 18'h00003, 16'h0000, RD_LAT, 16'h0008, 18'h00003, 3, 0, 1'b0, 1'b0, 16'h0008};
    vecs[9] = '{2'b10, 1'b1, 1'b0, 1'b0, 32'h0007_FFFE, 16'h0000, 1'b1, 18'h3FFFF, 16'hBEEF, RD_LAT, 16'hBEEF, 18'h3FFFF, 3, 0, 1'b0, 1'b0, 16'hBEEF};

    repeat (3) @(negedge clk);
    chk("rst_clkena", {31'd0, cpu_clkena}, 32'd0);
    chk("rst_dat_r", {16'd0, cpu_dat_r}, 32'd0);
    chk("rst_ctrl", {26'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, 32'h3E);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dat_w", {16'd0, sram_dat_w}, 32'd0);

    // No-access cycles held: clkena every second cycle, chip never enabled.
    cpu_busstate = 2'b01;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("noacc_clkena", {31'd0, cpu_clkena}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("noacc_ce_n", {31'd0, sram_ce_n}, 32'd1);
    end
    $display("txn noacc_stream: 8 cycles");

    // Reset asserted while a write strobe is active.
    mem[18'h38] = 16'h0000;
    cpu_busstate = 2'b11; cpu_we_n = 1'b0; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
    cpu_adr = 32'h70; cpu_dat_w = 16'h9999;
    @(negedge clk);
    chk("midrst_setup_we_n", {31'd0, sram_we_n}, 32'd1);
    @(negedge clk);
    chk("midrst_access_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctrl", {28'd0, sram_we_n, sram_ce_n, sram_dq_oe, cpu_clkena}, 32'hC);
    chk("midrst_dat_r", {16'd0, cpu_dat_r}, 32'd0);
    chk("midrst_addr", {14'd0, sram_addr}, 32'd0);
    chk("midrst_mem", {16'd0, mem[18'h38]}, 32'h9999);
    $display("txn midrst_write: mem[38]=%h", mem[18'h38]);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_en) mem[vecs[i].pre_addr] = vecs[i].pre_val;
      run_txn(vecs[i], lat, oe_cnt, we_cnt, ce_cnt, addr_seen, ub_seen, lb_seen, dat_r);
      wl = vecs[i].exp_lat;
      chk($sformatf("v%0d_latency", i), lat, wl);
      chk($sformatf("v%0d_dat_r", i), {16'd0, dat_r}, {16'd0, vecs[i].exp_dat_r});
      chk($sformatf("v%0d_oe_cycles", i), oe_cnt, vecs[i].exp_oe);
      chk($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].exp_we);
      chk($sformatf("v%0d_ce_cycles", i), ce_cnt, wl - 2);
      chk($sformatf("v%0d_mem", i), {16'd0, mem[vecs[i].pre_addr]}, {16'd0, vecs[i].exp_mem});
      if (wl > 2) begin
        chk($sformatf("v%0d_addr", i), {14'd0, addr_seen}, {14'd0, vecs[i].exp_addr});
        chk($sformatf("v%0d_lanes", i), {30'd0, ub_seen, lb_seen}, {30'd0, vecs[i].exp_ub, vecs[i].exp_lb});
      end
      $display("txn %0d bs=%b adr=%h lat=%0d oe=%0d we=%0d dat_r=%h", i, vecs[i].bs,
               vecs[i].adr, lat, oe_cnt, we_cnt, dat_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
